// File: rtl/div_stall_ctrl_if.sv
// rtl/div_stall_ctrl_if.sv - E-stage divider handshake: operands and cancel in, stall and hi/lo result out
interface div_stall_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancel;
  logic             div_stall;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;

  modport master (
    output div_startE, signedE, srcaE, srcbE, cancel,
    input  div_stall, hilo_we, hi_out, lo_out, busy
  );

  modport slave (
    input  div_startE, signedE, srcaE, srcbE, cancel,
    output div_stall, hilo_we, hi_out, lo_out, busy
  );
endinterface

// File: rtl/div_stall_ctrl.sv
// rtl/div_stall_ctrl.sv - iterative restoring DIV/DIVU with pipeline stall; DIV_EARLY_TERM_EN skips RUN for trivial divides
module div_stall_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  div_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_dvnd;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_we;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_start;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_b_zero;
  logic             w_early;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_lo_fin;
  logic [WIDTH-1:0] w_hi_fin;

  assign w_start  = (r_state == S_IDLE) & bus.div_startE & ~bus.cancel;
  assign w_a_neg  = bus.signedE & bus.srcaE[WIDTH-1];
  assign w_b_neg  = bus.signedE & bus.srcbE[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -bus.srcaE : bus.srcaE;
  assign w_b_abs  = w_b_neg ? -bus.srcbE : bus.srcbE;
  assign w_b_zero = (bus.srcbE == '0);

`ifdef DIV_EARLY_TERM_EN
  assign w_early = w_b_zero | (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif

  // The shifted partial remainder needs one extra bit: divisors above 2^(WIDTH-1) can be exceeded only there.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvsr) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_last    = (r_count == CW'(WIDTH - 1));

  assign w_lo_fin = r_dz ? '1     : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
  assign w_hi_fin = r_dz ? r_dvnd : (r_neg_r ? -w_rem_nxt : w_rem_nxt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_dvnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_we    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_start) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_abs;
            r_dvsr  <= w_b_abs;
            r_dvnd  <= bus.srcaE;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= w_b_zero;
            if (w_early) begin
              // Quotient is zero (or divide-by-zero): remainder is the raw dividend either way.
              r_hi    <= bus.srcaE;
              r_lo    <= w_b_zero ? '1 : '0;
              r_we    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            r_count <= '0;
            r_state <= S_IDLE;
          end else begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_hi    <= w_hi_fin;
              r_lo    <= w_lo_fin;
              r_we    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is gated by reset so a held start cannot freeze the pipe while the block is being reset.
  assign bus.div_stall = reset & (w_start | (r_state == S_RUN));
  assign bus.hilo_we   = r_we;
  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;
  assign bus.busy      = (r_state != S_IDLE);
endmodule
